// File: rtl/de_selector_1n_reg_pkg.sv
// Shared mode encoding for the registered 1-to-N de-selector.
package de_sel_pkg;

  localparam int MODE_HOLD_BIT = 0;
  localparam int MODE_SCAN_BIT = 1;

  localparam logic [1:0] MODE_DIRECT_CLEAR = 2'b00;
  localparam logic [1:0] MODE_DIRECT_HOLD  = 2'b01;
  localparam logic [1:0] MODE_SCAN_CLEAR   = 2'b10;
  localparam logic [1:0] MODE_SCAN_HOLD    = 2'b11;

  function automatic logic is_scan(input logic [1:0] mode);
    return mode[MODE_SCAN_BIT];
  endfunction

  function automatic logic is_hold(input logic [1:0] mode);
    return mode[MODE_HOLD_BIT];
  endfunction

endpackage

// File: rtl/de_selector_1n_reg_if.sv
// Producer-side bus of the de-selector: routed word, select, mode and channel outputs.
interface de_selector_1n_reg_if #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(N_OUT)
);

  logic [DATA_W-1:0]       iC;
  logic                    iValid;
  logic [SEL_W-1:0]        iS;
  logic [1:0]              iMode;
  logic [N_OUT*DATA_W-1:0] oZ;
  logic [N_OUT-1:0]        oZValid;
  logic [SEL_W-1:0]        oSel;
  logic                    oErr;

  modport master (
    output iC, iValid, iS, iMode,
    input  oZ, oZValid, oSel, oErr
  );

  modport slave (
    input  iC, iValid, iS, iMode,
    output oZ, oZValid, oSel, oErr
  );

endinterface

// File: rtl/de_selector_1n_reg_ptr.sv
// Mod-N_OUT wrap counter used as the scan-mode channel pointer.
module de_sel_ptr #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iClr,
  input  logic             iInc,
  output logic [SEL_W-1:0] oPtr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_next;

  // A clear coinciding with an increment means the word went to channel 0.
  always_comb begin
    w_ptr_next = r_ptr;
    if (iClr) begin
      w_ptr_next = iInc ? SEL_W'(1) : '0;
    end else if (iInc) begin
      w_ptr_next = (r_ptr == LAST) ? '0 : r_ptr + SEL_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign oPtr = r_ptr;

endmodule

// File: rtl/de_selector_1n_reg.sv
// Registered 1-to-N demultiplexer with direct/scan routing and clear/hold output policy.
module de_selector_1n_reg
  import de_sel_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  de_selector_1n_reg_if.slave  bus
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_OUT);

  logic             w_scan;
  logic             w_hold;
  logic             w_entry;
  logic             w_oor;
  logic             w_accept;
  logic [SEL_W-1:0] w_ptr;
  logic [SEL_W-1:0] w_target;
  logic [N_OUT-1:0] w_wr;

  logic             r_scan_prev;
  logic [N_OUT-1:0] r_zvalid;
  logic             r_err;

  assign w_scan   = is_scan(bus.iMode);
  assign w_hold   = is_hold(bus.iMode);
  assign w_entry  = w_scan & ~r_scan_prev;
  assign w_oor    = ~w_scan & ({1'b0, bus.iS} >= N_LIM);
  assign w_accept = bus.iValid & ~w_oor;

  // On the scan-entry edge the pointer is being cleared, so the word targets channel 0.
  assign w_target = w_scan ? (w_entry ? '0 : w_ptr) : bus.iS;
  assign bus.oSel = w_target;

  de_sel_ptr #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_ptr (
    .iClk (iClk),
    .iRst (iRst),
    .iClr (w_entry),
    .iInc (bus.iValid & w_scan),
    .oPtr (w_ptr)
  );

  always_comb begin
    w_wr = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (w_accept && (w_target == SEL_W'(k))) begin
        w_wr[k] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_chan
      logic [DATA_W-1:0] r_z;

      always_ff @(posedge iClk) begin
        if (iRst) begin
          r_z <= '0;
        end else if (w_wr[gi]) begin
          r_z <= bus.iC;
        end else if (!w_hold) begin
          r_z <= '0;
        end
      end

      assign bus.oZ[gi*DATA_W +: DATA_W] = r_z;
    end
  endgenerate

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_zvalid    <= '0;
      r_err       <= 1'b0;
      r_scan_prev <= 1'b0;
    end else begin
      r_zvalid    <= w_wr;
      r_err       <= bus.iValid & w_oor;
      r_scan_prev <= w_scan;
    end
  end

  assign bus.oZValid = r_zvalid;
  assign bus.oErr    = r_err;

endmodule

// File: tb/tb_de_selector_1n_reg.sv
// Bench: three de-selector configurations share one directed stimulus stream and a reference model.
module tb_de_selector_1n_reg;

  logic       clk = 1'b0;
  logic       st_rst = 1'b1;
  logic       st_valid = 1'b0;
  logic [7:0] st_c = '0;
  logic [1:0] st_s = '0;
  logic [1:0] st_mode = '0;

  int n_checks = 0;
  int n_errors = 0;
  int step_no = 0;
  logic [1:0] sel_c;

  initial forever #5 clk = ~clk;

  de_selector_1n_reg_if #(.N_OUT(4), .DATA_W(1)) if_a ();
  de_selector_1n_reg_if #(.N_OUT(4), .DATA_W(8)) if_b ();
  de_selector_1n_reg_if #(.N_OUT(3), .DATA_W(4)) if_c ();

  assign if_a.iC = st_c[0:0];
  assign if_b.iC = st_c;
  assign if_c.iC = st_c[3:0];
  assign if_a.iValid = st_valid;
  assign if_b.iValid = st_valid;
  assign if_c.iValid = st_valid;
  assign if_a.iS = st_s;
  assign if_b.iS = st_s;
  assign if_c.iS = st_s;
  assign if_a.iMode = st_mode;
  assign if_b.iMode = st_mode;
  assign if_c.iMode = st_mode;

  de_selector_1n_reg #(.N_OUT(4), .DATA_W(1)) u_a (.iClk(clk), .iRst(st_rst), .bus(if_a));
  de_selector_1n_reg #(.N_OUT(4), .DATA_W(8)) u_b (.iClk(clk), .iRst(st_rst), .bus(if_b));
  de_selector_1n_reg #(.N_OUT(3), .DATA_W(4)) u_c (.iClk(clk), .iRst(st_rst), .bus(if_c));

  // Reference model: per-configuration channel contents, pointer and last scan bit.
  int mn[3] = '{4, 4, 3};
  int mw[3] = '{1, 8, 4};
  int mz[3][16];
  int mzv[3];
  int merr[3];
  int mptr[3];
  int mprev[3];
  bit mvalid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_sel(input int d);
    if (!st_mode[1]) return int'(st_s);
    if (mprev[d] == 0) return 0;
    return mptr[d];
  endfunction

  function automatic logic [63:0] exp_z(input int d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < mn[d]; k++) r = r | (64'(mz[d][k]) << (k * mw[d]));
    return r;
  endfunction

  task automatic model_step(input int d);
    int tgt;
    bit scan;
    bit hold;
    bit oor;
    bit wr;
    if (st_rst) begin
      for (int k = 0; k < 16; k++) mz[d][k] = 0;
      mzv[d] = 0; merr[d] = 0; mptr[d] = 0; mprev[d] = 0;
      return;
    end
    tgt  = exp_sel(d);
    scan = st_mode[1];
    hold = st_mode[0];
    oor  = !scan && (int'(st_s) >= mn[d]);
    wr   = st_valid && !oor;
    for (int k = 0; k < mn[d]; k++) begin
      if (wr && k == tgt) mz[d][k] = int'(st_c) % (1 << mw[d]);
      else if (!hold)     mz[d][k] = 0;
    end
    mzv[d]  = wr ? (1 << tgt) : 0;
    merr[d] = (st_valid && oor) ? 1 : 0;
    if (scan && st_valid)          mptr[d] = (tgt + 1) % mn[d];
    else if (scan && mprev[d] == 0) mptr[d] = 0;
    mprev[d] = scan ? 1 : 0;
  endtask

  task automatic cmp(input int d, input string tag, input logic [63:0] z, input logic [63:0] zv,
                     input logic [63:0] err, input logic [63:0] sel);
    check({tag, "_oZ"}, z, exp_z(d));
    check({tag, "_oZValid"}, zv, 64'(mzv[d]));
    check({tag, "_oErr"}, err, 64'(merr[d]));
    check({tag, "_oSel"}, sel, 64'(exp_sel(d)));
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        cmp(0, "A", 64'(if_a.oZ), 64'(if_a.oZValid), 64'(if_a.oErr), 64'(if_a.oSel));
        cmp(1, "B", 64'(if_b.oZ), 64'(if_b.oZValid), 64'(if_b.oErr), 64'(if_b.oSel));
        cmp(2, "C", 64'(if_c.oZ), 64'(if_c.oZValid), 64'(if_c.oErr), 64'(if_c.oSel));
      end
      for (int d = 0; d < 3; d++) model_step(d);
      if (st_rst) mvalid = 1'b1;
    end
  end

  task automatic step(input logic r, input logic v, input logic [7:0] c,
                      input logic [1:0] s, input logic [1:0] m);
    st_rst = r; st_valid = v; st_c = c; st_s = s; st_mode = m;
    #1;
    sel_c = if_c.oSel;
    step_no++;
    $display("step %0d: rst=%0b valid=%0b c=%02h s=%0d mode=%02b selC=%0d",
             step_no, r, v, c, s, m, sel_c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, two cycles
    step(1'b1, 1'b0, 8'h00, 2'd0, 2'b00);
    step(1'b1, 1'b0, 8'h00, 2'd0, 2'b00);
    check("rst_A_oZ", 64'(if_a.oZ), 64'h0);
    check("rst_A_oZValid", 64'(if_a.oZValid), 64'h0);
    check("rst_B_oZ", 64'(if_b.oZ), 64'h0);
    check("rst_C_oErr", 64'(if_c.oErr), 64'h0);

    // Direct-clear on A
    step(1'b0, 1'b1, 8'h01, 2'd2, 2'b00);
    check("dc_A_oZ", 64'(if_a.oZ), 64'h4);
    check("dc_A_oZValid", 64'(if_a.oZValid), 64'h4);
    step(1'b0, 1'b0, 8'h00, 2'd0, 2'b00);
    check("dc_idle_A_oZ", 64'(if_a.oZ), 64'h0);
    check("dc_idle_A_oZValid", 64'(if_a.oZValid), 64'h0);

    // Direct-hold on B
    step(1'b0, 1'b1, 8'hA5, 2'd0, 2'b01);
    check("dh_B_v0", 64'(if_b.oZValid), 64'h1);
    step(1'b0, 1'b1, 8'h3C, 2'd3, 2'b01);
    check("dh_B_v3", 64'(if_b.oZValid), 64'h8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 2'd0, 2'b01);
      check("dh_B_oZ_hold", 64'(if_b.oZ), 64'h3C0000A5);
      check("dh_B_oZValid_idle", 64'(if_b.oZValid), 64'h0);
    end

    // Scan wrap on C: channels 0,1,2,0,1 then idle
    step(1'b0, 1'b1, 8'h01, 2'd0, 2'b10);
    check("scan_C_sel0", 64'(sel_c), 64'd0);
    step(1'b0, 1'b1, 8'h02, 2'd0, 2'b11);
    check("scan_C_sel1", 64'(sel_c), 64'd1);
    step(1'b0, 1'b1, 8'h03, 2'd0, 2'b11);
    check("scan_C_sel2", 64'(sel_c), 64'd2);
    step(1'b0, 1'b1, 8'h04, 2'd0, 2'b11);
    check("scan_C_sel3", 64'(sel_c), 64'd0);
    step(1'b0, 1'b1, 8'h05, 2'd0, 2'b11);
    check("scan_C_sel4", 64'(sel_c), 64'd1);
    check("scan_C_oZ", 64'(if_c.oZ), 64'h354);
    step(1'b0, 1'b0, 8'h00, 2'd0, 2'b11);
    check("scan_C_sel5", 64'(sel_c), 64'd2);
    check("scan_C_oZ_idle", 64'(if_c.oZ), 64'h354);

    // Out-of-range select on C, hold then clear policy
    step(1'b0, 1'b1, 8'h0F, 2'd3, 2'b01);
    check("oor_C_oErr", 64'(if_c.oErr), 64'h1);
    check("oor_C_oZValid", 64'(if_c.oZValid), 64'h0);
    check("oor_C_oZ_hold", 64'(if_c.oZ), 64'h354);
    step(1'b0, 1'b1, 8'h0F, 2'd3, 2'b00);
    check("oor_C_oZ_clear", 64'(if_c.oZ), 64'h0);
    check("oor_C_oErr2", 64'(if_c.oErr), 64'h1);
    step(1'b0, 1'b0, 8'h00, 2'd0, 2'b00);
    check("oor_C_oErr_idle", 64'(if_c.oErr), 64'h0);

    // Scan re-entry: pointer reaches 2, leave scan, re-enter with a word
    step(1'b0, 1'b1, 8'h07, 2'd0, 2'b11);
    step(1'b0, 1'b1, 8'h08, 2'd0, 2'b11);
    step(1'b0, 1'b0, 8'h00, 2'd0, 2'b01);
    step(1'b0, 1'b1, 8'h09, 2'd0, 2'b11);
    check("reentry_C_sel", 64'(sel_c), 64'd0);
    check("reentry_C_oZValid", 64'(if_c.oZValid), 64'h1);
    check("reentry_C_oZ", 64'(if_c.oZ), 64'h089);

    // Reset with a word in flight
    step(1'b1, 1'b1, 8'h0A, 2'd1, 2'b11);
    check("midrst_C_oZ", 64'(if_c.oZ), 64'h0);
    check("midrst_C_oZValid", 64'(if_c.oZValid), 64'h0);
    check("midrst_B_oZ", 64'(if_b.oZ), 64'h0);
    step(1'b0, 1'b0, 8'h00, 2'd0, 2'b11);
    step(1'b0, 1'b1, 8'h0B, 2'd2, 2'b11);
    check("postrst_C_sel", 64'(sel_c), 64'd0);
    check("postrst_C_oZValid", 64'(if_c.oZValid), 64'h1);
    check("postrst_C_oZ", 64'(if_c.oZ), 64'h00B);
    step(1'b0, 1'b0, 8'h00, 2'd0, 2'b11);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
